// File: rtl/prog_mem_pkg.sv
// prog_mem_pkg: shared definitions for the program memory block.
//   state_e       - loader FSM encoding (StIdle, StWrite)
//   DefAddrW      - default byte-address width
//   DefWordBytes  - default bytes per fetched instruction word
package prog_mem_pkg;

    typedef enum logic {
        StIdle  = 1'b0,
        StWrite = 1'b1
    } state_e;

    localparam int unsigned DefAddrW     = 8;
    localparam int unsigned DefWordBytes = 4;

endpackage

// File: rtl/prog_mem_if.sv
// prog_mem_if: programming and fetch bus of the program memory.
//   edit, unit, code, send      - loader side (master drives)
//   address                     - fetch byte address (master drives)
//   opcode                      - registered fetched word (slave drives)
//   busy, ack, overrun          - loader status (slave drives)
//   wr_count, checksum          - loader statistics (slave drives)
// Modports: master (host / bench), slave (prog_mem).
interface prog_mem_if import prog_mem_pkg::*; #(
    parameter int unsigned ADDR_W     = DefAddrW,
    parameter int unsigned WORD_BYTES = DefWordBytes
);
    logic                    edit;
    logic [ADDR_W-1:0]       unit;
    logic [7:0]              code;
    logic                    send;
    logic [ADDR_W-1:0]       address;
    logic [8*WORD_BYTES-1:0] opcode;
    logic                    busy;
    logic                    ack;
    logic                    overrun;
    logic [15:0]             wr_count;
    logic [7:0]              checksum;

    modport master (
        output edit, unit, code, send, address,
        input  opcode, busy, ack, overrun, wr_count, checksum
    );

    modport slave (
        input  edit, unit, code, send, address,
        output opcode, busy, ack, overrun, wr_count, checksum
    );
endinterface

// File: rtl/prog_mem_loader.sv
// prog_mem_loader: byte loader for the program memory.
//   clk, rst      - clock, synchronous active-high reset
//   edit_i        - programming mode enable
//   unit_i        - requested byte address
//   code_i        - byte to program
//   send_i        - write request (rising edge only)
//   we_o, waddr_o, wdata_o - memory write port
//   busy_o, ack_o, overrun_o, wr_count_o, checksum_o - status
// Optional feature: PROG_MEM_CHECKSUM_EN enables the running byte checksum;
// without it checksum_o is tied to zero.
module prog_mem_loader import prog_mem_pkg::*; #(
    parameter int unsigned ADDR_W   = DefAddrW,
    parameter int unsigned AUTO_INC = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              edit_i,
    input  logic [ADDR_W-1:0] unit_i,
    input  logic [7:0]        code_i,
    input  logic              send_i,
    output logic              we_o,
    output logic [ADDR_W-1:0] waddr_o,
    output logic [7:0]        wdata_o,
    output logic              busy_o,
    output logic              ack_o,
    output logic              overrun_o,
    output logic [15:0]       wr_count_o,
    output logic [7:0]        checksum_o
);
    state_e            state_q, state_d;
    logic              send_q, edit_q;
    logic              req_q, req_d;
    logic              ack_q;
    logic              overrun_q, overrun_d;
    logic              ptr_valid_q, ptr_valid_d, ptr_valid_eff;
    logic [ADDR_W-1:0] addr_q, addr_d, ptr_q, ptr_d, target;
    logic [7:0]        data_q, data_d;
    logic [15:0]       cnt_q, cnt_d;
    logic              rise, busy, accept;

    assign rise   = send_i & ~send_q;
    assign busy   = (state_q == StWrite);
    assign accept = edit_i & rise & ~busy;

    // A rising edit starts a new session, so the pointer reloads from unit.
    assign ptr_valid_eff = ptr_valid_q & ~(edit_i & ~edit_q);
    assign target = ((AUTO_INC != 0) && ptr_valid_eff) ? ptr_q : unit_i;

    always_comb begin
        state_d     = state_q;
        req_d       = accept;
        addr_d      = addr_q;
        data_d      = data_q;
        ptr_d       = ptr_q;
        ptr_valid_d = ptr_valid_eff;
        overrun_d   = overrun_q | (edit_i & rise & busy);
        cnt_d       = cnt_q;
        if (accept) begin
            addr_d      = target;
            data_d      = code_i;
            ptr_d       = target + ADDR_W'(1);
            ptr_valid_d = 1'b1;
        end
        unique case (state_q)
            StIdle: begin
                if (req_q) begin
                    state_d = StWrite;
                end
            end
            StWrite: begin
                state_d = StIdle;
                if (cnt_q != 16'hFFFF) begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StIdle;
            send_q      <= 1'b0;
            edit_q      <= 1'b0;
            req_q       <= 1'b0;
            ack_q       <= 1'b0;
            overrun_q   <= 1'b0;
            ptr_valid_q <= 1'b0;
            ptr_q       <= '0;
            addr_q      <= '0;
            data_q      <= '0;
            cnt_q       <= '0;
        end else begin
            state_q     <= state_d;
            send_q      <= send_i;
            edit_q      <= edit_i;
            req_q       <= req_d;
            ack_q       <= busy;
            overrun_q   <= overrun_d;
            ptr_valid_q <= ptr_valid_d;
            ptr_q       <= ptr_d;
            addr_q      <= addr_d;
            data_q      <= data_d;
            cnt_q       <= cnt_d;
        end
    end

`ifdef PROG_MEM_CHECKSUM_EN
    logic [7:0] sum_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            sum_q <= 8'h00;
        end else if (busy) begin
            sum_q <= sum_q + data_q;
        end
    end

    assign checksum_o = sum_q;
`else
    assign checksum_o = 8'h00;
`endif

    // Reset in the WRITE cycle suppresses the memory write.
    assign we_o       = busy & ~rst;
    assign waddr_o    = addr_q;
    assign wdata_o    = data_q;
    assign busy_o     = busy;
    assign ack_o      = ack_q;
    assign overrun_o  = overrun_q;
    assign wr_count_o = cnt_q;
endmodule

// File: rtl/prog_mem.sv
// prog_mem: byte-programmable instruction memory with a word fetch port.
//   clk  - sole clock
//   rst  - synchronous active-high reset (array contents are kept)
//   bus  - prog_mem_if.slave: loader inputs, fetch address, opcode, status
// Fetch returns mem[address] in the MSB byte followed by the next
// WORD_BYTES-1 bytes, wrapping at the top of the array, one cycle later.
// Optional feature: PROG_MEM_CHECKSUM_EN (see prog_mem_loader).
module prog_mem import prog_mem_pkg::*; #(
    parameter int unsigned ADDR_W     = DefAddrW,
    parameter int unsigned WORD_BYTES = DefWordBytes,
    parameter int unsigned AUTO_INC   = 0
) (
    input  logic     clk,
    input  logic     rst,
    prog_mem_if.slave bus
);
    localparam int unsigned Depth = 2 ** ADDR_W;
    localparam int unsigned OpW   = 8 * WORD_BYTES;

    logic [7:0]        mem_q [Depth];
    logic              we;
    logic [ADDR_W-1:0] waddr;
    logic [7:0]        wdata;
    logic [OpW-1:0]    word;
    logic [OpW-1:0]    opcode_q, opcode_d;

    prog_mem_loader #(
        .ADDR_W   (ADDR_W),
        .AUTO_INC (AUTO_INC)
    ) u_loader (
        .clk        (clk),
        .rst        (rst),
        .edit_i     (bus.edit),
        .unit_i     (bus.unit),
        .code_i     (bus.code),
        .send_i     (bus.send),
        .we_o       (we),
        .waddr_o    (waddr),
        .wdata_o    (wdata),
        .busy_o     (bus.busy),
        .ack_o      (bus.ack),
        .overrun_o  (bus.overrun),
        .wr_count_o (bus.wr_count),
        .checksum_o (bus.checksum)
    );

    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[waddr] <= wdata;
        end
    end

    // Index arithmetic is ADDR_W bits wide, so it wraps naturally.
    always_comb begin
        word = '0;
        for (int unsigned b = 0; b < WORD_BYTES; b++) begin
            word[8*(WORD_BYTES-1-b) +: 8] = mem_q[bus.address + ADDR_W'(b)];
        end
    end

    assign opcode_d = bus.edit ? '0 : word;

    always_ff @(posedge clk) begin
        if (rst) begin
            opcode_q <= '0;
        end else begin
            opcode_q <= opcode_d;
        end
    end

    assign bus.opcode = opcode_q;
endmodule

// File: tb/tb_prog_mem.sv
// tb_prog_mem: directed self-checking bench for prog_mem.
// dut1 uses AUTO_INC=0, dut2 uses AUTO_INC=1; both share clock and reset.
module tb_prog_mem;
    logic clk;
    logic rst;
    int   n_checks;
    int   n_errors;
    int   acks;

    prog_mem_if #(.ADDR_W(8), .WORD_BYTES(4)) bus1 ();
    prog_mem_if #(.ADDR_W(8), .WORD_BYTES(4)) bus2 ();

    prog_mem #(.ADDR_W(8), .WORD_BYTES(4), .AUTO_INC(0)) dut1 (
        .clk (clk),
        .rst (rst),
        .bus (bus1)
    );

    prog_mem #(.ADDR_W(8), .WORD_BYTES(4), .AUTO_INC(1)) dut2 (
        .clk (clk),
        .rst (rst),
        .bus (bus2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic wr1(input logic [7:0] a, input logic [7:0] d);
        bus1.unit = a;
        bus1.code = d;
        bus1.send = 1'b1;
        tick();
        bus1.send = 1'b0;
        tick();
        tick();
        tick();
    endtask

    task automatic wr2(input logic [7:0] a, input logic [7:0] d);
        bus2.unit = a;
        bus2.code = d;
        bus2.send = 1'b1;
        tick();
        bus2.send = 1'b0;
        tick();
        tick();
        tick();
    endtask

    logic [7:0] exp_sum;

    initial begin
        n_checks = 0;
        n_errors = 0;
        rst = 1'b1;
        bus1.edit = 0; bus1.unit = 0; bus1.code = 0; bus1.send = 0; bus1.address = 0;
        bus2.edit = 0; bus2.unit = 0; bus2.code = 0; bus2.send = 0; bus2.address = 0;
        do_reset();

        // Reset state
        check("rst_opcode", bus1.opcode, 32'h0);
        check("rst_busy", bus1.busy, 1'b0);
        check("rst_ack", bus1.ack, 1'b0);
        check("rst_overrun", bus1.overrun, 1'b0);
        check("rst_wr_count", bus1.wr_count, 16'h0);
        check("rst_checksum", bus1.checksum, 8'h0);

        // Basic programming and fetch
        bus1.edit = 1'b1;
        tick();
        wr1(8'h04, 8'hFF);
        wr1(8'h05, 8'h00);
        wr1(8'h06, 8'h1F);
        wr1(8'h07, 8'h02);
        bus1.edit = 1'b0;
        bus1.address = 8'h04;
        tick();
        check("fetch_04", bus1.opcode, 32'hFF001F02);
        check("count_4", bus1.wr_count, 16'd4);
`ifdef PROG_MEM_CHECKSUM_EN
        exp_sum = 8'h20;
`else
        exp_sum = 8'h00;
`endif
        check("checksum_4", bus1.checksum, exp_sum);

        // Wrap at the top of the array
        bus1.edit = 1'b1;
        tick();
        wr1(8'hFE, 8'h11);
        wr1(8'hFF, 8'h22);
        wr1(8'h00, 8'h33);
        wr1(8'h01, 8'h44);
        bus1.edit = 1'b0;
        bus1.address = 8'hFE;
        tick();
        check("fetch_wrap", bus1.opcode, 32'h11223344);
        check("count_8", bus1.wr_count, 16'd8);

        // Same-cycle fetch and write returns old data; edit falling mid-write
        bus1.edit = 1'b1;
        tick();
        wr1(8'h40, 8'h12);
        bus1.unit = 8'h40;
        bus1.code = 8'h34;
        bus1.send = 1'b1;
        tick();
        bus1.send = 1'b0;
        bus1.edit = 1'b0;
        bus1.address = 8'h40;
        tick();
        check("busy_in_write", bus1.busy, 1'b1);
        tick();
        check("old_data", bus1.opcode[31:24], 8'h12);
        check("ack_edit_low", bus1.ack, 1'b1);
        tick();
        check("new_data", bus1.opcode[31:24], 8'h34);
        check("ack_one_cycle", bus1.ack, 1'b0);

        // Held send produces a single write
        do_reset();
        bus1.edit = 1'b1;
        bus1.unit = 8'h10;
        bus1.code = 8'hAA;
        bus1.send = 1'b1;
        acks = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (bus1.ack) acks++;
        end
        bus1.send = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            if (bus1.ack) acks++;
        end
        check("held_send_acks", acks, 1);
        check("held_send_count", bus1.wr_count, 16'd1);
        bus1.edit = 1'b0;
        bus1.address = 8'h10;
        tick();
        check("held_send_data", bus1.opcode[31:24], 8'hAA);

        // Send edge with edit=0 is ignored
        do_reset();
        wr1(8'h10, 8'h55);
        check("edit0_count", bus1.wr_count, 16'd0);
        check("edit0_overrun", bus1.overrun, 1'b0);

        // Overrun: second edge while busy is dropped
        bus1.edit = 1'b1;
        bus1.unit = 8'h30;
        bus1.code = 8'h5A;
        bus1.send = 1'b1;
        tick();
        bus1.send = 1'b0;
        bus1.code = 8'hA5;
        tick();
        bus1.send = 1'b1;
        tick();
        bus1.send = 1'b0;
        tick();
        tick();
        tick();
        check("overrun_set", bus1.overrun, 1'b1);
        check("overrun_count", bus1.wr_count, 16'd1);
        tick();
        check("overrun_sticky", bus1.overrun, 1'b1);
        do_reset();
        check("overrun_clr", bus1.overrun, 1'b0);

        // Auto-increment pointer (dut2)
        bus2.edit = 1'b1;
        tick();
        wr2(8'hF0, 8'h01);
        wr2(8'h55, 8'h02);
        wr2(8'h66, 8'h03);
        wr2(8'h77, 8'h04);
        bus2.edit = 1'b0;
        bus2.address = 8'hF0;
        tick();
        check("autoinc_fetch", bus2.opcode, 32'h01020304);
        check("autoinc_count", bus2.wr_count, 16'd4);

        // Reset during WRITE aborts the write
        do_reset();
        bus1.edit = 1'b1;
        tick();
        wr1(8'h20, 8'h77);
        bus1.unit = 8'h20;
        bus1.code = 8'h55;
        bus1.send = 1'b1;
        tick();
        bus1.send = 1'b0;
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("abort_ack_rst", bus1.ack, 1'b0);
        tick();
        check("abort_ack", bus1.ack, 1'b0);
        check("abort_count", bus1.wr_count, 16'd0);
        check("abort_busy", bus1.busy, 1'b0);
        check("edit_opcode_zero", bus1.opcode, 32'h0);
        bus1.edit = 1'b0;
        bus1.address = 8'h20;
        tick();
        check("abort_mem", bus1.opcode[31:24], 8'h77);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/prog_mem.md
PROG_MEM -- requirements
Module: prog_mem

Interface
REQ-001 Parameter ADDR_W, default 8, byte-address width; depth = 2**ADDR_W bytes.
REQ-002 Parameter WORD_BYTES, default 4, bytes per fetched instruction word (1..8).
REQ-003 Parameter AUTO_INC, default 0; 1 = loader pointer auto-increments after first write of an edit session.
REQ-004 clk  in  1  sole clock; all state changes on rising edge.
REQ-005 rst  in  1  reset, synchronous, active-high.
REQ-006 edit  in  1  programming mode enable.
REQ-007 unit  in  ADDR_W  byte address to program.
REQ-008 code  in  8  byte to program.
REQ-009 send  in  1  write request; only a rising edge (send=1, previous-cycle send=0) is a request.
REQ-010 address  in  ADDR_W  fetch byte address.
REQ-011 opcode  out  8*WORD_BYTES  registered fetched word.
REQ-012 busy  out  1  loader FSM not IDLE.
REQ-013 ack  out  1  one-cycle pulse per completed byte write.
REQ-014 overrun  out  1  sticky: request dropped while busy.
REQ-015 wr_count  out  16  bytes written since reset, saturating at 16'hFFFF.
REQ-016 checksum  out  8  running 8-bit modulo-256 sum of written bytes (see Configuration).

Function
REQ-017 Fetch: opcode <= {mem[address], mem[address+1], ..., mem[address+WORD_BYTES-1]}, mem[address] in MSB byte, index modulo 2**ADDR_W (wrap at top); latency 1 cycle.
REQ-018 opcode SHALL be registered 0 on any cycle where edit=1 is sampled.
REQ-019 Same-cycle fetch and write to one byte: fetch returns old data.
REQ-020 Loader FSM states IDLE, WRITE; IDLE->WRITE on edit=1 and send rising edge, latching target address and code; WRITE->IDLE unconditionally after one cycle.
REQ-021 In WRITE: mem[latched addr] <= latched code; ack=1 next cycle for exactly one cycle; wr_count +1 (saturating).
REQ-022 Target address: unit when AUTO_INC=0; when AUTO_INC=1, unit for first request after edit rises, then pointer+1 per write, wrapping 2**ADDR_W-1 -> 0.
REQ-023 Send rising edge while busy=1: no write, overrun <= 1; overrun cleared only by rst.
REQ-024 Send rising edge with edit=0: ignored, no flag.
REQ-025 edit falling during WRITE: write still completes and acks.
REQ-026 send held high across many cycles produces exactly one write.

Reset
REQ-027 On rst=1: FSM IDLE, opcode=0, busy=0, ack=0, overrun=0, wr_count=0, checksum=0, send edge register=0, AUTO_INC pointer reloads from unit on next request.
REQ-028 rst=1 during WRITE aborts: no memory write, no ack; send edge in a rst cycle ignored.
REQ-029 Memory array contents are not cleared by rst.

Configuration
REQ-030 Macro PROG_MEM_CHECKSUM_EN defined: checksum <= checksum + code each completed write, mod 256.
REQ-031 Macro undefined: checksum tied to 8'h00, no adder or register present.

Structure
REQ-032 Shared package prog_mem_pkg holds FSM state encoding (IDLE, WRITE) and defaults for ADDR_W/WORD_BYTES.
REQ-033 One sub-module, prog_mem_loader: edge detect, FSM, pointer, overrun, wr_count, checksum; prog_mem holds array and fetch port.

Verification
REQ-034 rst, edit=1, writes unit 04..07 codes FF,00,1F,02, edit=0, address=04 -> opcode=32'hFF001F02 one cycle later; wr_count=4; checksum=8'h20 with macro, 8'h00 without.
REQ-035 send held 1 for 10 cycles, unit=10, code=AA -> one ack pulse, wr_count=1.
REQ-036 Write FE..FF and 00..01 with 11,22,33,44, address=FE -> opcode=32'h11223344 (wrap).
REQ-037 Two send rising edges on consecutive cycles -> second dropped, overrun=1, wr_count=1; rst -> overrun=0.
REQ-038 AUTO_INC=1, unit=F0, four sends code 01..04 -> mem[F0..F3]=01..04 regardless of later unit values; address=F0 -> 32'h01020304.
REQ-039 rst asserted in WRITE cycle for unit=20, code=55 -> no ack, mem[20] unchanged, wr_count=0; edit=1 -> opcode=0.
